// File: rtl/speaker_serializer.sv
// rtl/speaker_serializer.sv - stereo sample serializer driving an audio DAC (optional SPEAKER_I2S_MODE_EN)
module speaker_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_in_left,
  input  logic [15:0] audio_in_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_strobe
);

  logic [8:0]  div_cnt;
  logic [15:0] shadow_l;
  logic [15:0] shadow_r;
  logic        sdin_q;
  logic        strobe_q;
  logic        capture;
  logic        sck_fall;
  logic [4:0]  next_k;
  logic        next_bit;

  // The wrap edge of the divider is the only point where new samples enter.
  assign capture  = (div_cnt == 9'd511);
  // SCK falls where the low nibble wraps, so data changes there and is stable at the rising edge.
  assign sck_fall = (div_cnt[3:0] == 4'hF);
  assign next_k   = div_cnt[8:4] + 5'd1;

`ifdef SPEAKER_I2S_MODE_EN
  logic       prev_r_lsb;
  logic [3:0] i2s_idx;

  // Index 16-k (mod 16) selects bits 15..1 for periods 1..15 and 17..31.
  assign i2s_idx = 4'd0 - next_k[3:0];

  // Select the bit for the upcoming SCK period, delayed one period behind LRCK.
  always_comb begin
    next_bit = 1'b0;
    if (next_k[3:0] == 4'd0) begin
      next_bit = next_k[4] ? shadow_l[0] : prev_r_lsb;
    end else begin
      next_bit = next_k[4] ? shadow_r[i2s_idx] : shadow_l[i2s_idx];
    end
  end

  // Hold the right LSB across the capture edge so it can lead the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r_lsb <= 1'b0;
    end else if (sck_fall && next_k == 5'd31) begin
      prev_r_lsb <= shadow_r[0];
    end
  end
`else
  // Select the bit for the upcoming SCK period; period 0 bypasses the shadow for zero latency.
  always_comb begin
    next_bit = 1'b0;
    if (next_k == 5'd0) begin
      next_bit = audio_in_left[15];
    end else if (!next_k[4]) begin
      next_bit = shadow_l[4'd15 - next_k[3:0]];
    end else begin
      next_bit = shadow_r[4'd15 - next_k[3:0]];
    end
  end
`endif

  // Free-running divider from which every DAC clock is derived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 9'd0;
    end else begin
      div_cnt <= div_cnt + 9'd1;
    end
  end

  // Capture both channels once per frame; other edges ignore the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_l <= 16'd0;
      shadow_r <= 16'd0;
    end else if (capture) begin
      shadow_l <= audio_in_left;
      shadow_r <= audio_in_right;
    end
  end

  // Serial data register, updated only on SCK falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdin_q <= 1'b0;
    end else if (sck_fall) begin
      sdin_q <= next_bit;
    end
  end

  // Strobe is high for the single cycle in which div_cnt sits at 0 after a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= capture;
    end
  end

  assign audio_mclk    = div_cnt[1];
  assign audio_sck     = div_cnt[3];
  assign audio_lrck    = div_cnt[8];
  assign audio_sdin    = sdin_q;
  assign sample_strobe = strobe_q;

endmodule
